// File: rtl/fifo_status_ctrl.sv
// Pointer, occupancy and status controller for a DATADEPTH-entry FIFO; any depth >= 2.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow error flags.
module fifo_status_ctrl #(
  parameter int unsigned DATADEPTH  = 45,
  parameter int unsigned AFULL_LVL  = DATADEPTH - 4,
  parameter int unsigned AEMPTY_LVL = 4,
  localparam int unsigned AW        = $clog2(DATADEPTH),
  localparam int unsigned CW        = $clog2(DATADEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW-1:0] B_W_address,
  output logic [AW-1:0] B_R_address,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW-1:0] LastAddr  = AW'(DATADEPTH - 1);
  localparam logic [CW-1:0] FullCnt   = CW'(DATADEPTH);
  localparam logic [CW-1:0] AfullCnt  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AemptyCnt = CW'(AEMPTY_LVL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;

  // Acceptance looks only at registered flags, so a pop never frees room for a same-cycle push.
  always_comb begin
    wr_ok = wr_en & ~full_q;
    rd_ok = rd_en & ~empty_q;
  end

  // Explicit wrap compare keeps non-power-of-2 depths correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    full_d   = (count_d == FullCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfullCnt);
    aempty_d = (count_d <= AemptyCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign B_W_address = wr_ptr_q;
  assign B_R_address = rd_ptr_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign afull       = afull_q;
  assign aempty      = aempty_q;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Bench for fifo_status_ctrl: directed boundary sequences plus randomized traffic
// checked against an occupancy/modulo-address reference model.
module tb_fifo_status_ctrl;

  localparam int unsigned D  = 45;
  localparam int unsigned AF = D - 4;
  localparam int unsigned AE = 4;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_ok, rd_ok;
  logic [AW-1:0] B_W_address, B_R_address;
  logic [CW-1:0] count;
  logic          full, empty, afull, aempty, overflow, underflow;

  fifo_status_ctrl #(
    .DATADEPTH (D),
    .AFULL_LVL (AF),
    .AEMPTY_LVL(AE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_ok      (wr_ok),
    .rd_ok      (rd_ok),
    .B_W_address(B_W_address),
    .B_R_address(B_R_address),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .afull      (afull),
    .aempty     (aempty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: occupancy and absolute push/pop totals.
  int m_level;
  int m_pushes;
  int m_pops;
  bit m_ovf;
  bit m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level  = 0;
    m_pushes = 0;
    m_pops   = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_state();
    check_eq("count", 32'(count), 32'(m_level));
    check_eq("full", 32'(full), 32'(m_level == D));
    check_eq("empty", 32'(empty), 32'(m_level == 0));
    check_eq("afull", 32'(afull), 32'(m_level >= AF));
    check_eq("aempty", 32'(aempty), 32'(m_level <= AE));
    check_eq("waddr", 32'(B_W_address), 32'(m_pushes % D));
    check_eq("raddr", 32'(B_R_address), 32'(m_pops % D));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Starts and ends at a falling edge; covers one rising edge.
  task automatic step(input logic w, input logic r);
    bit acc_w, acc_r;
    wr_en = w;
    rd_en = r;
    #1;
    acc_w = w && (m_level != D);
    acc_r = r && (m_level != 0);
    check_eq("wr_ok", 32'(wr_ok), 32'(acc_w));
    check_eq("rd_ok", 32'(rd_ok), 32'(acc_r));
`ifdef FIFO_ERR_FLAGS_EN
    if (w && m_level == D) m_ovf = 1'b1;
    if (r && m_level == 0) m_unf = 1'b1;
`endif
    if (acc_w) m_pushes++;
    if (acc_r) m_pops++;
    m_level = m_level + int'(acc_w) - int'(acc_r);
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  initial begin
    int wp, rp;
    int pct_w[6] = '{80, 20, 50, 97, 3, 55};
    int pct_r[6] = '{20, 80, 50, 3, 97, 45};

    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state();
    @(negedge clk);
    check_state();

    // Fill to full and push once more.
    for (int i = 1; i <= 45; i++) begin
      step(1'b1, 1'b0);
      if (i == 40) check_eq("afull_at_40", 32'(afull), 32'd0);
      if (i == 41) check_eq("afull_at_41", 32'(afull), 32'd1);
    end
    check_eq("full_after_45", 32'(full), 32'd1);
    check_eq("count_after_45", 32'(count), 32'd45);
    check_eq("waddr_wrapped", 32'(B_W_address), 32'd0);
    step(1'b1, 1'b0);

    // Drain to empty and pop once more.
    for (int i = 1; i <= 45; i++) begin
      step(1'b0, 1'b1);
      if (i == 40) check_eq("aempty_at_5", 32'(aempty), 32'd0);
      if (i == 41) check_eq("aempty_at_4", 32'(aempty), 32'd1);
    end
    check_eq("empty_after_drain", 32'(empty), 32'd1);
    check_eq("raddr_wrapped", 32'(B_R_address), 32'd0);
    step(1'b0, 1'b1);

    // Simultaneous requests at empty then at full.
    step(1'b1, 1'b1);
    check_eq("both_at_empty_count", 32'(count), 32'd1);
    for (int i = 0; i < 44; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("both_at_full_count", 32'(count), 32'd44);
    check_eq("both_at_full_full", 32'(full), 32'd0);

    // Hold at 10 with continuous push+pop.
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
    check_eq("steady_count", 32'(count), 32'd10);
    check_eq("steady_ptr_gap",
             32'((int'(B_W_address) - int'(B_R_address) + 45) % 45), 32'd10);

    // Asynchronous reset mid-burst at 23.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
    check_eq("pre_reset_count", 32'(count), 32'd23);
    wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    check_eq("post_reset_waddr", 32'(B_W_address), 32'd0);
    check_eq("post_reset_wr_ok", 32'(wr_ok), 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    m_level  = 1;
    m_pushes = 1;
    check_state();

    // Randomized traffic in phases biased toward each boundary.
    for (int ph = 0; ph < 6; ph++) begin
      wp = pct_w[ph];
      rp = pct_r[ph];
      for (int i = 0; i < 300; i++) begin
        step(logic'($urandom_range(99) < wp), logic'($urandom_range(99) < rp));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_status_ctrl.md
Name: fifo_status_ctrl

Overview:
- Parametrised synchronous FIFO pointer and status controller for a DATADEPTH-entry buffer.
- Non-power-of-2 depths are supported, e.g. 45 entries.
- Owns the read and write address counters, qualifies push/pop requests, and produces registered full/empty, almost-full/almost-empty, fill level and error flags.
- Sits between the producer/consumer handshake and the dual-port storage RAM, replacing the pointer-equality-plus-direction scheme with an occupancy counter.

Parameters:
- DATADEPTH, 45, number of storage entries; legal range >= 2.
- AFULL_LVL, DATADEPTH-4, afull asserts when count >= AFULL_LVL; legal range 1..DATADEPTH-1.
- AEMPTY_LVL, 4, aempty asserts when count <= AEMPTY_LVL; legal range 0..DATADEPTH-2.
- Derived widths: AW = $clog2(DATADEPTH), CW = $clog2(DATADEPTH+1).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, producer push request.
- rd_en, input, 1, consumer pop request.
- wr_ok, output, 1, combinational; push accepted this cycle (RAM write enable).
- rd_ok, output, 1, combinational; pop accepted this cycle (RAM read enable).
- B_W_address, output, AW, current write address to RAM.
- B_R_address, output, AW, current read address to RAM.
- count, output, CW, registered occupancy, 0..DATADEPTH.
- full, output, 1, registered; count == DATADEPTH.
- empty, output, 1, registered; count == 0.
- afull, output, 1, registered; count >= AFULL_LVL.
- aempty, output, 1, registered; count <= AEMPTY_LVL.
- overflow, output, 1, sticky; push attempted while full (ERR_FLAGS_EN only).
- underflow, output, 1, sticky; pop attempted while empty (ERR_FLAGS_EN only).

Behaviour:
- Reset (async assert, sync release):
  - B_W_address = 0, B_R_address = 0, count = 0.
  - empty = 1, full = 0, aempty = 1, afull = 0, overflow = 0, underflow = 0.
  - Reset asserted mid-operation discards all contents immediately; the controller needs no flush cycle.
- Acceptance:
  - wr_ok = wr_en & ~full.
  - rd_ok = rd_en & ~empty.
  - Both are qualified only by the registered flags, with no same-cycle pass-through. When full, a simultaneous rd_en and wr_en gives a pop only; when empty, it gives a push only.
- Pointers:
  - On wr_ok, B_W_address increments.
  - On rd_ok, B_R_address increments.
  - Each pointer wraps from DATADEPTH-1 to 0 by explicit compare, not by binary rollover, so non-power-of-2 depths work.
- Count:
  - Next count = count + wr_ok - rd_ok.
  - Simultaneous accepted push and pop leaves count, full, empty, afull and aempty unchanged while both pointers advance.
- Flags:
  - All flags are computed from next count and registered.
  - Latency is 1 cycle: an accepted push on edge N makes empty = 0 visible after edge N.
  - full and empty are never both 1.
  - B_W_address == B_R_address holds exactly when full or empty.
- Wrap-around: at DATADEPTH = 45, pointer value 44 plus one push gives 0; the count is unaffected by wrap.
- Data storage, RAM timing and output data registering are outside this block.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with wr_en & full.
  - underflow sets on any cycle with rd_en & empty.
  - Both hold until rst_n is asserted.
  - The rejected request does not move pointers or count.
- Not defined: overflow and underflow are tied to 0 and no sticky flops are inferred. Acceptance behaviour is identical in both builds.

Test Plan:
1. Release reset, no requests -> count = 0, empty = 1, aempty = 1, full = 0, afull = 0, both addresses 0.
2. DATADEPTH = 45: 45 consecutive pushes ->
   - afull rises the cycle after the 41st push (count = 41).
   - full = 1 and count = 45 after the 45th push.
   - B_W_address = 0, wrapped.
   - A 46th push gives wr_ok = 0, and overflow = 1 with FIFO_ERR_FLAGS_EN.
3. From full, 45 pops ->
   - aempty rises at count = 4.
   - empty = 1 after the last pop, B_R_address = 0.
   - A further pop gives rd_ok = 0, and underflow = 1 with FIFO_ERR_FLAGS_EN.
4. Count = 10, wr_en = rd_en = 1 for 50 cycles -> count stays 10, flags unchanged, both pointers wrap past 44 with B_W_address - B_R_address ≡ 10 mod 45.
5. Simultaneous requests at boundaries:
   - At full with wr_en = rd_en = 1 -> only a pop, count = 44, full = 0.
   - At empty with wr_en = rd_en = 1 -> only a push, count = 1, empty = 0.
6. Assert rst_n low mid-burst at count = 23 -> all outputs take reset values asynchronously in the same cycle; after release, the next push lands at B_W_address 0.
